// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI framebuffer read path: FSM states,
// bus word size and the pixels-to-words helper also used by hdmi_core.
package hdmi_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_ISSUE    = 3'd2,
    S_INFLIGHT = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // bpp4=0 packs two 16-bit pixels per word, so an odd hres rounds up.
  function automatic logic [10:0] line_words(input logic [10:0] hres, input logic bpp4);
    logic [11:0] half;
    half = ({1'b0, hres} + 12'd1) >> 1;
    return bpp4 ? hres : half[10:0];
  endfunction

endpackage

// File: rtl/hdmi_read_scheduler.sv
// Turns hdmi_core read strobes into word-aligned burst commands for the
// pixel-FIFO bus master; tracks line/chunk position and pending chunk requests.
module hdmi_read_scheduler
  import hdmi_pkg::*;
#(
  parameter int CHUNK_WORDS = 16,
  parameter int PEND_MAX    = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [10:0]       hres,
  input  logic              num_bytes_per_pixel,
  input  logic              read_go,
  input  logic              read_next_line,
  input  logic              read_next_chunk,
  input  logic              read_done,
  output logic              mst_req,
  output logic [ADDR_W-1:0] mst_addr,
  output logic [4:0]        mst_len,
  input  logic              mst_ack,
  input  logic              mst_done,
  output logic              busy,
  output logic [10:0]       line_count,
  output logic              req_overrun
);

  localparam int PW = $clog2(PEND_MAX + 1);
  localparam int WB = $clog2(BYTES_PER_WORD);
  localparam logic [10:0]   CHUNK_W  = 11'(CHUNK_WORDS);
  localparam logic [PW-1:0] PEND_TOP = PW'(PEND_MAX);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] line_addr, line_addr_nx, addr_nx, line_bytes;
  logic [10:0]       word_off, word_off_nx, lc_nx, lw, rem;
  logic [PW-1:0]     pending, pending_nx;
  logic [1:0]        line_pend, line_pend_nx;
  logic              done_pend, done_pend_nx, ovr_nx;
  logic [4:0]        len_nx, chunk_len;
  logic              cnt_en, pend_clr, pend_dec;

  assign lw         = line_words(hres, num_bytes_per_pixel);
  assign line_bytes = ADDR_W'(lw) << WB;
  assign rem        = lw - word_off;
  assign chunk_len  = (rem > CHUNK_W) ? CHUNK_W[4:0] : rem[4:0];
  assign mst_req    = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nx     = state;
    line_addr_nx = line_addr;
    word_off_nx  = word_off;
    lc_nx        = line_count;
    pending_nx   = pending;
    line_pend_nx = line_pend;
    done_pend_nx = done_pend;
    ovr_nx       = req_overrun;
    addr_nx      = mst_addr;
    len_nx       = mst_len;
    cnt_en       = 1'b0;
    pend_clr     = 1'b0;
    pend_dec     = 1'b0;

    case (state)
      S_IDLE: begin
        if (read_go) begin
          state_nx     = S_WAIT;
          line_addr_nx = frame_base;
          word_off_nx  = '0;
          lc_nx        = '0;
          pending_nx   = '0;
          line_pend_nx = '0;
          done_pend_nx = 1'b0;
          ovr_nx       = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_en = 1'b1;
        if (read_done) begin
          state_nx     = S_IDLE;
          cnt_en       = 1'b0;
          pending_nx   = '0;
          line_pend_nx = '0;
        end else if (read_next_line || line_pend != 2'd0) begin
          // Deferred line advances are retired here, one per cycle, before any issue.
          line_addr_nx = line_addr + line_bytes;
          word_off_nx  = '0;
          lc_nx        = line_count + 11'd1;
          pend_clr     = 1'b1;
          line_pend_nx = line_pend + {1'b0, read_next_line} - 2'd1;
        end else if (pending != '0) begin
          if (word_off < lw) begin
            state_nx = S_ISSUE;
            addr_nx  = line_addr + (ADDR_W'(word_off) << WB);
            len_nx   = chunk_len;
          end else begin
            pend_dec = 1'b1;
            ovr_nx   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_en       = 1'b1;
        line_pend_nx = (line_pend == 2'd3) ? line_pend : line_pend + {1'b0, read_next_line};
        done_pend_nx = done_pend | read_done;
        if (mst_ack) begin
          state_nx    = S_INFLIGHT;
          pend_dec    = 1'b1;
          word_off_nx = word_off + 11'(mst_len);
        end
      end
      S_INFLIGHT: begin
        cnt_en       = 1'b1;
        line_pend_nx = (line_pend == 2'd3) ? line_pend : line_pend + {1'b0, read_next_line};
        done_pend_nx = done_pend | read_done;
        if (mst_done) state_nx = (done_pend || read_done) ? S_DRAIN : S_WAIT;
      end
      S_DRAIN: begin
        state_nx     = S_IDLE;
        pending_nx   = '0;
        line_pend_nx = '0;
        done_pend_nx = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase

    // A strobe coinciding with a retire leaves the count unchanged.
    if (cnt_en) begin
      if (pend_clr) begin
        pending_nx = PW'(read_next_chunk);
      end else if (read_next_chunk && !pend_dec) begin
        if (pending == PEND_TOP) ovr_nx = 1'b1;
        else                     pending_nx = pending + PEND_ONE;
      end else if (!read_next_chunk && pend_dec) begin
        pending_nx = pending - PEND_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      line_addr   <= '0;
      word_off    <= '0;
      line_count  <= '0;
      pending     <= '0;
      line_pend   <= '0;
      done_pend   <= 1'b0;
      req_overrun <= 1'b0;
      mst_addr    <= '0;
      mst_len     <= '0;
    end else begin
      state       <= state_nx;
      line_addr   <= line_addr_nx;
      word_off    <= word_off_nx;
      line_count  <= lc_nx;
      pending     <= pending_nx;
      line_pend   <= line_pend_nx;
      done_pend   <= done_pend_nx;
      req_overrun <= ovr_nx;
      mst_addr    <= addr_nx;
      mst_len     <= len_nx;
    end
  end

endmodule

// File: tb/tb_hdmi_read_scheduler.sv
// Directed bench for hdmi_read_scheduler with a frame/line/word reference model
// and a responder that acks one cycle after a request and completes bursts later.
module tb_hdmi_read_scheduler;

  logic        clock, reset;
  logic [31:0] frame_base;
  logic [10:0] hres;
  logic        num_bytes_per_pixel;
  logic        read_go, read_next_line, read_next_chunk, read_done;
  logic        mst_req;
  logic [31:0] mst_addr;
  logic [4:0]  mst_len;
  logic        mst_ack, mst_done;
  logic        busy;
  logic [10:0] line_count;
  logic        req_overrun;

  hdmi_read_scheduler #(.CHUNK_WORDS(16), .PEND_MAX(4), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .frame_base(frame_base), .hres(hres),
    .num_bytes_per_pixel(num_bytes_per_pixel), .read_go(read_go),
    .read_next_line(read_next_line), .read_next_chunk(read_next_chunk),
    .read_done(read_done), .mst_req(mst_req), .mst_addr(mst_addr),
    .mst_len(mst_len), .mst_ack(mst_ack), .mst_done(mst_done), .busy(busy),
    .line_count(line_count), .req_overrun(req_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position in lines and words
  logic [31:0] m_base;
  int          m_lw, m_line, m_words;
  bit          m_allow;

  int          cmd_count = 0;
  logic [31:0] log_addr [64];
  logic [4:0]  log_len  [64];

  // Responder state
  int ack_wait = 0, done_wait = 0, done_lat = 20;
  bit stall_ack = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [31:0] b, input int h, input bit bpp4);
    frame_base = b; hres = 11'(h); num_bytes_per_pixel = bpp4;
    m_base = b; m_lw = bpp4 ? h : (h + 1) / 2; m_line = 0; m_words = 0; m_allow = 1;
    read_go = 1; step(); read_go = 0;
  endtask

  task automatic chunk();
    read_next_chunk = 1; step(); read_next_chunk = 0;
  endtask

  task automatic next_line();
    m_line++; m_words = 0;
    read_next_line = 1; step(); read_next_line = 0;
  endtask

  task automatic done_strobe();
    m_allow = 0;
    read_done = 1; step(); read_done = 0;
  endtask

  task automatic wait_cmds(input int target);
    int n = 0;
    while (!(cmd_count >= target && !mst_req && ack_wait == 0 && done_wait == 0) && n < 300) begin
      step(); n++;
    end
    if (n >= 300) fail_now($sformatf("timeout waiting for command %0d (seen %0d)", target, cmd_count));
    step(3);
  endtask

  task automatic wait_inflight();
    int n = 0;
    while (done_wait == 0 && n < 100) begin step(); n++; end
    if (n >= 100) fail_now("timeout waiting for burst acceptance");
  endtask

  // Bus master model: ack one cycle after request seen, done done_lat cycles later
  initial begin
    mst_ack = 0; mst_done = 0;
    forever begin
      @(posedge clock); #1;
      mst_ack = 0; mst_done = 0;
      if (done_wait > 0) begin
        done_wait--;
        if (done_wait == 0) mst_done = 1;
      end else if (mst_req && !stall_ack) begin
        ack_wait++;
        if (ack_wait >= 2) begin
          mst_ack = 1; ack_wait = 0; done_wait = done_lat;
        end
      end
    end
  end

  // Compare process: every command against the model, held stable until ack
  initial begin
    logic        prev_req;
    logic [31:0] held_addr, exp_addr;
    logic [4:0]  held_len;
    int          r, exp_len;
    prev_req = 0; held_addr = 0; held_len = 0;
    forever begin
      @(negedge clock);
      if (!reset && mst_req) begin
        if (!prev_req) begin
          if (cmd_count < 64) begin
            log_addr[cmd_count] = mst_addr;
            log_len[cmd_count]  = mst_len;
          end
          cmd_count++;
          if (!m_allow || m_words >= m_lw) begin
            fail_now($sformatf("unexpected command addr=0x%0h len=%0d", mst_addr, mst_len));
          end else begin
            r = m_lw - m_words;
            exp_len  = (r > 16) ? 16 : r;
            exp_addr = m_base + 32'(m_line * m_lw * 4 + m_words * 4);
            check("cmd_addr", mst_addr, exp_addr);
            check("cmd_len", 32'(mst_len), 32'(exp_len));
            check("busy_during_cmd", 32'(busy), 32'd1);
            m_words += exp_len;
          end
          held_addr = mst_addr;
          held_len  = mst_len;
        end else begin
          check("cmd_addr_stable", mst_addr, held_addr);
          check("cmd_len_stable", 32'(mst_len), 32'(held_len));
        end
      end
      prev_req = mst_req;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c4, c5, c6, n;
    reset = 1; frame_base = 0; hres = 0; num_bytes_per_pixel = 0;
    read_go = 0; read_next_line = 0; read_next_chunk = 0; read_done = 0;
    m_base = 0; m_lw = 0; m_line = 0; m_words = 0; m_allow = 0;
    step(3);
    check("rst_mst_req", 32'(mst_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_line_count", 32'(line_count), 0);
    check("rst_overrun", 32'(req_overrun), 0);
    check("rst_mst_addr", mst_addr, 0);
    check("rst_mst_len", 32'(mst_len), 0);
    reset = 0;
    step(2);

    // 1: chunk addressing
    go(32'h1000_0000, 1280, 0);
    check("t1_busy", 32'(busy), 1);
    chunk(); wait_cmds(1);
    chunk(); wait_cmds(2);
    check("t1_addr0", log_addr[0], 32'h1000_0000);
    check("t1_len0", 32'(log_len[0]), 16);
    check("t1_addr1", log_addr[1], 32'h1000_0040);
    check("t1_len1", 32'(log_len[1]), 16);

    // 2: line advance during a burst, 2 bytes/pixel
    chunk(); wait_inflight(); step();
    next_line();
    wait_cmds(3);
    check("t2_line_count", 32'(line_count), 1);
    chunk(); wait_cmds(4);
    check("t2_addr", log_addr[3], 32'h1000_0A00);
    check("t2_len", 32'(log_len[3]), 16);

    // 3: line advance in WAIT, 4 bytes/pixel
    done_strobe(); step(2);
    check("t3_idle_busy", 32'(busy), 0);
    go(32'h1000_0000, 1280, 1);
    next_line(); chunk(); wait_cmds(5);
    check("t3_addr", log_addr[4], 32'h1000_1400);
    check("t3_len", 32'(log_len[4]), 16);
    check("t3_line_count", 32'(line_count), 1);

    // 4: short last chunk, then a request past end of line
    done_strobe(); step(2);
    done_lat = 4;
    go(32'h2000_0000, 1288, 0);
    c4 = cmd_count;
    for (int i = 0; i < 41; i++) begin
      chunk(); wait_cmds(c4 + i + 1);
    end
    check("t4_addr40", log_addr[c4 + 39], 32'h2000_09C0);
    check("t4_addr41", log_addr[c4 + 40], 32'h2000_0A00);
    check("t4_len41", 32'(log_len[c4 + 40]), 4);
    check("t4_no_overrun_yet", 32'(req_overrun), 0);
    chunk(); step(6);
    check("t4_extra_issued", 32'(cmd_count), 32'(c4 + 41));
    check("t4_overrun", 32'(req_overrun), 1);

    // 5: pending saturation with ack stalled
    done_strobe(); step(2);
    check("t5_overrun_kept_idle", 32'(req_overrun), 1);
    go(32'h3000_0000, 1280, 0);
    check("t5_overrun_cleared", 32'(req_overrun), 0);
    c5 = cmd_count;
    stall_ack = 1;
    for (int i = 0; i < 6; i++) chunk();
    step(3);
    check("t5_overrun", 32'(req_overrun), 1);
    check("t5_req_held", 32'(mst_req), 1);
    stall_ack = 0;
    wait_cmds(c5 + 4);
    step(40);
    check("t5_cmds", 32'(cmd_count), 32'(c5 + 4));

    // 6: end of frame with requests still pending, then restart
    done_strobe(); step(2);
    done_lat = 20;
    go(32'h4000_0000, 1280, 0);
    frame_base = 32'hDEAD_0000;
    next_line();
    c6 = cmd_count;
    chunk(); chunk(); chunk();
    wait_inflight(); step();
    done_strobe();
    n = 0;
    while (mst_done !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) fail_now("timeout waiting for mst_done");
    @(negedge clock);
    check("t6_busy_drain", 32'(busy), 1);
    @(negedge clock);
    check("t6_busy_idle", 32'(busy), 0);
    step(30);
    check("t6_cmds", 32'(cmd_count), 32'(c6 + 1));
    check("t6_addr", log_addr[c6], 32'h4000_0A00);
    check("t6_line_count_idle", 32'(line_count), 1);
    go(32'h5000_0000, 640, 1);
    check("t6_restart_busy", 32'(busy), 1);
    check("t6_restart_line_count", 32'(line_count), 0);
    check("t6_restart_overrun", 32'(req_overrun), 0);
    chunk(); wait_cmds(c6 + 2);
    check("t6_restart_addr", log_addr[c6 + 1], 32'h5000_0000);
    check("t6_restart_len", 32'(log_len[c6 + 1]), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_read_scheduler.md
Name: hdmi_read_scheduler

Overview:
- Sequences framebuffer reads for hdmi_core.
- Converts hdmi_core's read strobes (read_go, read_next_line, read_next_chunk, read_done) into word-aligned burst requests on a bus-master command interface.
- Computes line and chunk addresses from the frame base, hres and pixel format.
- Sits between hdmi_core and the PLB/AXI master that fills the pixel FIFO.

Parameters:
- CHUNK_WORDS, 16, maximum burst length in 32-bit words per chunk.
- PEND_MAX, 4, depth of the pending-chunk-request counter.
- ADDR_W, 32, bus address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_base  in  ADDR_W  framebuffer base, byte address, 4-byte aligned
- hres  in  11  active pixels per line
- num_bytes_per_pixel  in  1  0: 2 bytes/pixel (2 pixels per word); 1: 4 bytes/pixel
- read_go  in  1  start-of-frame strobe from hdmi_core
- read_next_line  in  1  advance-to-next-line strobe
- read_next_chunk  in  1  chunk request strobe
- read_done  in  1  end-of-frame strobe
- mst_req  out  1  burst command valid
- mst_addr  out  ADDR_W  burst start byte address
- mst_len  out  5  burst length in words, 1..CHUNK_WORDS
- mst_ack  in  1  command accepted
- mst_done  in  1  burst data fully written to FIFO
- busy  out  1  frame active
- line_count  out  11  lines advanced in current frame
- req_overrun  out  1  sticky: dropped chunk request

Behaviour:
- Reset values: all outputs 0; state IDLE; pending counter 0.
- Derived values:
  - line_words = bpp0 ? ceil(hres/2) : hres
  - line_bytes = line_words*4
  - widths are sized for hres up to 2047 with no overflow (line_words 11 bits, line_bytes 13 bits)
- States: IDLE, WAIT, ISSUE, INFLIGHT, DRAIN.
- IDLE:
  - read_go latches frame_base into line_addr and the shadow base; word_off=0; line_count=0; pending=0; busy=1 next cycle.
  - Go to WAIT.
  - All other strobes are ignored in IDLE.
- WAIT:
  - If pending>0 and word_off<line_words: go to ISSUE next cycle and present the command.
    - mst_addr = line_addr + word_off*4
    - mst_len = min(CHUNK_WORDS, line_words-word_off)
  - If pending>0 and word_off>=line_words: pending is decremented, req_overrun is set, and nothing is issued.
- ISSUE:
  - mst_req is held high, with addr/len stable, until mst_ack.
  - On ack: mst_req=0 in the same cycle's next edge; pending decrements; word_off += mst_len; go to INFLIGHT.
- INFLIGHT: on mst_done, go to WAIT, or to DRAIN if read_done is pending.
- read_next_chunk:
  - Increments pending, saturating at PEND_MAX.
  - A request at saturation sets req_overrun.
  - Simultaneous strobe and ack: net pending unchanged.
- read_next_line:
  - In WAIT it applies immediately: line_addr += line_bytes; word_off=0; line_count++; pending cleared.
  - In ISSUE/INFLIGHT it is latched as line_pend and applied on the cycle after mst_done, before any new issue.
  - A second next_line while line_pend is set is also counted (two-deep counter). Lines are never dropped.
- read_done:
  - In WAIT it goes to IDLE next cycle.
  - In ISSUE/INFLIGHT it is latched. The current command completes (ack then done) and the block then goes to IDLE via DRAIN (one cycle).
  - busy=0 in IDLE.
  - Pending requests and line_pend are discarded.
- read_go while not IDLE: ignored.
- frame_base changes mid-frame have no effect until the next read_go.
- req_overrun clears only on reset or read_go.
- Reset mid-burst: the block returns to IDLE immediately and mst_req drops the next cycle. The master is reset by the same reset.

Decomposition:
- Shared package hdmi_pkg holds:
  - state encoding localparams (S_IDLE..S_DRAIN)
  - BYTES_PER_WORD=4
  - the line_words function shared with hdmi_core
- No sub-module; the address/length arithmetic stays inline.

Test Plan:
1. Chunk addressing:
   - Stimulus: hres=1280, bpp=0, base=0x10000000; read_go, then read_next_chunk ×2 (ack 1 cycle after req, done 20 cycles later).
   - Response: commands (0x10000000,16) then (0x10000040,16).
2. Line advance, 2 bytes/pixel:
   - Stimulus: as test 1, then read_next_line during INFLIGHT, then read_next_chunk.
   - Response: line change applied after mst_done; line_count=1; next command 0x10000A00, len 16.
3. Line advance, 4 bytes/pixel:
   - Stimulus: hres=1280, bpp=1; read_go, read_next_line, read_next_chunk.
   - Response: command 0x10001400, len 16.
4. Short last chunk:
   - Stimulus: hres=1288, bpp=0; issue 41 chunks.
   - Response: the 41st command is at base+0xA00 with len 4.
   - A 42nd request issues nothing and sets req_overrun=1.
5. Pending saturation:
   - Stimulus: stall mst_ack low; pulse read_next_chunk 6 times.
   - Response: exactly 4 commands issue after ack resumes; req_overrun=1.
6. End of frame:
   - Stimulus: read_done during INFLIGHT, with 2 chunks pending.
   - Response: no further mst_req; busy=0 one cycle after DRAIN.
   - A new read_go restarts at the new frame_base with line_count=0 and req_overrun=0.
